// File: rtl/vmem_pkg.sv
// Shared types and constants for the frame-buffer rectangle fill path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vmem_pkg;

  localparam int unsigned X_W          = 10;
  localparam int unsigned Y_W          = 9;
  localparam int unsigned ADDR_W       = X_W + Y_W;
  localparam int unsigned RGB_W        = 24;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  // One latched fill command: inclusive corners plus colour.
  typedef struct packed {
    logic [X_W-1:0]   x0;
    logic [Y_W-1:0]   y0;
    logic [X_W-1:0]   x1;
    logic [Y_W-1:0]   y1;
    logic [RGB_W-1:0] color;
  } fill_cmd_t;

  // Frame-buffer address layout: column in the high bits, row in the low bits.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    return {x, y};
  endfunction

  // A rectangle is unusable if its corners are swapped or it leaves the
  // visible area. All comparisons are unsigned.
  function automatic logic rect_invalid(input fill_cmd_t   c,
                                        input int unsigned h_lim,
                                        input int unsigned v_lim);
    logic [31:0] x1_w;
    logic [31:0] y1_w;
    x1_w = {22'd0, c.x1};
    y1_w = {23'd0, c.y1};
    return (c.x0 > c.x1) || (c.y0 > c.y1) || (x1_w >= h_lim) || (y1_w >= v_lim);
  endfunction

endpackage

// File: rtl/rect_raster_cnt.sv
// Raster-order (x,y) walker over an inclusive rectangle, loaded once per fill.
// Latency: load/step take effect on the next clock; x_o/y_o/last_o are registered state.
// Backpressure: holds position whenever step_i is low; never advances past the last pixel.
module rect_raster_cnt
  import vmem_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [X_W-1:0] x0_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [X_W-1:0] x1_i,
  input  logic [Y_W-1:0] y1_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  logic [X_W-1:0] x_q,  x_d;
  logic [Y_W-1:0] y_q,  y_d;
  logic [X_W-1:0] x0_q, x0_d;
  logic [X_W-1:0] x1_q, x1_d;
  logic [Y_W-1:0] y1_q, y1_d;
  logic           last;

  assign last = (x_q == x1_q) && (y_q == y1_q);

  // Next position: load corners, or advance one pixel in raster order.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    x0_d = x0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    if (load_i) begin
      x_d  = x0_i;
      y_d  = y0_i;
      x0_d = x0_i;
      x1_d = x1_i;
      y1_d = y1_i;
    end else if (step_i && !last) begin
      // The final pixel is never stepped past, so neither counter can
      // run beyond the rectangle's far corner.
      if (x_q == x1_q) begin
        x_d = x0_q;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position and bound registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = last;

endmodule

// File: rtl/vmem_fill_ctrl.sv
// Rectangle fill sequencer: one command in, one vmem write per permitted cycle in raster order.
// Latency: accept at N, first write at N+2, done pulse at N+2+pixels when never stalled.
// Backpressure: cmd_ready only in IDLE; writes stall (no skip/repeat) while vga_valid is high.
module vmem_fill_ctrl
  import vmem_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter bit          BLANK_ONLY = 1'b1
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_W-1:0]    cmd_x0,
  input  logic [Y_W-1:0]    cmd_y0,
  input  logic [X_W-1:0]    cmd_x1,
  input  logic [Y_W-1:0]    cmd_y1,
  input  logic [RGB_W-1:0]  cmd_color,
  input  logic              abort,
  input  logic              vga_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [RGB_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  fill_state_t    state_q, state_d;
  fill_cmd_t      cmd_q,   cmd_d;
  logic           accept;
  logic           reject;
  logic           wr_ok;
  logic           cnt_load;
  logic           cnt_step;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           cur_last;

  assign accept = (state_q == ST_IDLE) && cmd_valid;
  assign reject = rect_invalid(cmd_q, H_ACTIVE, V_ACTIVE);

  // Scanout owns the frame buffer during active video; abort always wins.
  assign wr_ok = (!BLANK_ONLY || !vga_valid) && !abort;

  // Command fields are captured only at the handshake and ignored afterwards.
  always_comb begin
    cmd_d = cmd_q;
    if (accept) begin
      cmd_d.x0    = cmd_x0;
      cmd_d.y0    = cmd_y0;
      cmd_d.x1    = cmd_x1;
      cmd_d.y1    = cmd_y1;
      cmd_d.color = cmd_color;
    end
  end

  // Latched command register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and outputs; write strobe and data are combinational so a
  // stalled cycle costs nothing and the counters simply hold.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    done      = 1'b0;
    err       = 1'b0;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (reject) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wr_ok) begin
          wr_en    = 1'b1;
          wr_addr  = pack_addr(cur_x, cur_y);
          wr_data  = cmd_q.color;
          cnt_step = 1'b1;
          if (cur_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  rect_raster_cnt u_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (cnt_load),
    .step_i (cnt_step),
    .x0_i   (cmd_q.x0),
    .y0_i   (cmd_q.y0),
    .x1_i   (cmd_q.x1),
    .y1_i   (cmd_q.y1),
    .x_o    (cur_x),
    .y_o    (cur_y),
    .last_o (cur_last)
  );

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Self-checking bench for vmem_fill_ctrl: table-driven commands plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_vmem_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0;
  logic [8:0]  cmd_y0 = '0;
  logic [9:0]  cmd_x1 = '0;
  logic [8:0]  cmd_y1 = '0;
  logic [23:0] cmd_color = '0;
  logic        abort = 1'b0;
  logic        vga_valid = 1'b0;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  vmem_fill_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .abort     (abort),
    .vga_valid (vga_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  x1;
    logic [8:0]  y1;
    logic [23:0] color;
    bit          toggle;
    bit          exp_err;
    string       name;
  } vec_t;

  typedef struct packed {
    logic [18:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_wr = 0, n_done = 0, n_err = 0, n_acc = 0;
  int   last_wr_cyc = 0, last_done_cyc = 0, last_err_cyc = 0, last_acc_cyc = 0;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic vec_t mk(input int x0, input int y0, input int x1, input int y1,
                              input logic [23:0] c, input bit tog, input bit e, input string n);
    vec_t v;
    v.x0 = 10'(x0); v.y0 = 9'(y0); v.x1 = 10'(x1); v.y1 = 9'(y1);
    v.color = c; v.toggle = tog; v.exp_err = e; v.name = n;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_wr++;
      last_wr_cyc = cyc;
      chk("blank_gate", {31'd0, vga_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {13'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {13'd0, wr_addr}, {13'd0, e.addr});
        chk("wr_data", {8'd0, wr_data}, {8'd0, e.data});
      end
    end
    if (done === 1'b1) begin n_done++; last_done_cyc = cyc; end
    if (err === 1'b1)  begin n_err++;  last_err_cyc  = cyc; end
    if (cmd_valid && cmd_ready === 1'b1) begin n_acc++; last_acc_cyc = cyc; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rect(input vec_t v, input int limit);
    int n;
    n = 0;
    for (int y = int'(v.y0); y <= int'(v.y1); y++) begin
      for (int x = int'(v.x0); x <= int'(v.x1); x++) begin
        if (n < limit) exp_q.push_back({10'(x), 9'(y), v.color});
        n++;
      end
    end
  endtask

  // Present one command for exactly one handshake, then scramble the inputs.
  task automatic send(input vec_t v, input int limit, output int a_cyc);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin tick(); t++; end
    chk({v.name, "_ready_wait"}, {31'd0, cmd_ready}, 32'd1);
    if (!v.exp_err) push_rect(v, limit);
    cmd_x0 = v.x0; cmd_y0 = v.y0; cmd_x1 = v.x1; cmd_y1 = v.y1; cmd_color = v.color;
    cmd_valid = 1'b1;
    tick();
    a_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_x0 = 10'($urandom); cmd_y0 = 9'($urandom); cmd_x1 = 10'($urandom);
    cmd_y1 = 9'($urandom); cmd_color = 24'($urandom);
  endtask

  task automatic run_cmd(input vec_t v);
    int pix, d0, e0, w0, a_cyc, t, budget;
    pix = (int'(v.x1) - int'(v.x0) + 1) * (int'(v.y1) - int'(v.y0) + 1);
    budget = (v.exp_err ? 0 : 3 * pix) + 50;
    d0 = n_done; e0 = n_err; w0 = n_wr;
    send(v, 1 << 30, a_cyc);
    t = 0;
    while (n_done == d0 && n_err == e0 && t < budget) begin
      vga_valid = v.toggle ? (((cyc / 3) % 2) == 1) : 1'b0;
      tick();
      t++;
    end
    vga_valid = 1'b0;
    chk({v.name, "_timeout"}, (t < budget) ? 32'd1 : 32'd0, 32'd1);
    chk({v.name, "_err_cnt"},  n_err - e0,  v.exp_err ? 32'd1 : 32'd0);
    chk({v.name, "_done_cnt"}, n_done - d0, v.exp_err ? 32'd0 : 32'd1);
    chk({v.name, "_wr_cnt"},   n_wr - w0,   v.exp_err ? 32'd0 : 32'(pix));
    chk({v.name, "_q_empty"},  exp_q.size(), 32'd0);
    if (v.exp_err) begin
      chk({v.name, "_err_cyc"}, last_err_cyc, a_cyc);
      chk({v.name, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
      chk({v.name, "_ready_cyc"}, cyc, a_cyc + 1);
    end else begin
      chk({v.name, "_done_after_last"}, last_done_cyc, last_wr_cyc + 1);
      if (!v.toggle) chk({v.name, "_done_cyc"}, last_done_cyc, a_cyc + 1 + pix);
    end
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int a_cyc, d0, w0, acc0, first_done, t;
    vec_t v;

    vecs[0] = mk(2, 3, 4, 4, 24'hFF0000, 1'b0, 1'b0, "rect_blank");
    vecs[1] = mk(2, 3, 4, 4, 24'hFF0000, 1'b1, 1'b0, "rect_toggle");
    vecs[2] = mk(5, 3, 4, 4, 24'h00FF00, 1'b0, 1'b1, "x_order");
    vecs[3] = mk(0, 0, 640, 0, 24'h00FF00, 1'b0, 1'b1, "x_range");
    vecs[4] = mk(0, 5, 0, 4, 24'h0000FF, 1'b0, 1'b1, "y_order");
    vecs[5] = mk(0, 0, 0, 480, 24'h0000FF, 1'b0, 1'b1, "y_range");
    vecs[6] = mk(636, 477, 639, 479, 24'h123456, 1'b1, 1'b0, "corner");
    vecs[7] = mk(639, 479, 639, 479, 24'h00FF00, 1'b0, 1'b0, "last_px");
    vecs[8] = mk(0, 0, 0, 479, 24'h0000FF, 1'b0, 1'b0, "tall_col");

    // Reset state.
    repeat (3) tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_wr_en",     {31'd0, wr_en},     32'd0);
    chk("rst_wr_addr",   {13'd0, wr_addr},   32'd0);
    chk("rst_wr_data",   {8'd0, wr_data},    32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Abort after the 100th write of a full-screen fill.
    v = mk(0, 0, 639, 479, 24'hC0FFEE, 1'b0, 1'b0, "abort");
    d0 = n_done; w0 = n_wr;
    send(v, 100, a_cyc);
    t = 0;
    while (n_wr - w0 < 100 && t < 300) begin tick(); t++; end
    abort = 1'b1;
    #1;
    chk("abort_no_wr", {31'd0, wr_en}, 32'd0);
    tick();
    abort = 1'b0;
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_busy",  {31'd0, busy},      32'd0);
    repeat (5) tick();
    chk("abort_wr_cnt",   n_wr - w0,    32'd100);
    chk("abort_no_done",  n_done - d0,  32'd0);
    chk("abort_q_empty",  exp_q.size(), 32'd0);
    exp_q.delete();

    // Synchronous reset in the middle of a fill.
    v = mk(0, 0, 9, 9, 24'h5A5A5A, 1'b0, 1'b0, "rst_mid");
    send(v, 1 << 30, a_cyc);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    chk("rstmid_wr_en",     {31'd0, wr_en},     32'd0);
    chk("rstmid_busy",      {31'd0, busy},      32'd0);
    chk("rstmid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    exp_q.delete();
    w0 = n_wr;
    repeat (5) tick();
    chk("rstmid_dropped", n_wr - w0, 32'd0);
    run_cmd(mk(7, 7, 7, 7, 24'h777777, 1'b0, 1'b0, "single_px"));

    // cmd_valid held high: second handshake only once the first fill is done.
    v = mk(1, 1, 3, 1, 24'hABCDEF, 1'b0, 1'b0, "held");
    push_rect(v, 1 << 30);
    push_rect(v, 1 << 30);
    d0 = n_done; w0 = n_wr; acc0 = n_acc; first_done = -1;
    cmd_x0 = v.x0; cmd_y0 = v.y0; cmd_x1 = v.x1; cmd_y1 = v.y1; cmd_color = v.color;
    cmd_valid = 1'b1;
    t = 0;
    while (n_done - d0 < 2 && t < 100) begin
      tick();
      t++;
      if (first_done < 0 && n_done - d0 == 1) first_done = last_done_cyc;
    end
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("held_acc_cnt",  n_acc - acc0,  32'd2);
    chk("held_acc2_cyc", last_acc_cyc,  first_done + 1);
    chk("held_wr_cnt",   n_wr - w0,     32'd6);
    chk("held_q_empty",  exp_q.size(),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
